// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types and constants for the 4x4 keypad scan encoder.
//   kypd_state_e : debounce FSM states
//   scan_res_t   : one full-scan result, either NONE or a {row,col} position
//   LEGEND       : printed legend of each key, indexed by {row,col}
//   legend()     : position -> hex code lookup
package kypd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } kypd_state_e;

  typedef struct packed {
    logic       none;
    logic [3:0] pos;    // {row[1:0], col[1:0]}
  } scan_res_t;

  localparam scan_res_t RES_NONE = '{none: 1'b1, pos: 4'h0};

  // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  localparam logic [3:0] LEGEND [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [3:0] legend(input logic [3:0] pos);
    return LEGEND[pos];
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// keypad_scan_encoder_if: key-code handshake between the encoder and its consumer.
//   key_code  : hex legend of the confirmed key
//   key_valid : key_code holds an unconsumed press
//   key_ready : consumer accepts key_code while key_valid is high
//   key_held  : a confirmed key is currently held down
//   overrun   : one-cycle pulse, a confirmed press was dropped
// master = encoder side, slave = consumer side.
interface keypad_scan_encoder_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code, key_valid, key_held, overrun,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_held, overrun,
    output key_ready
  );
endinterface

// File: rtl/kypd_row_sync.sv
// kypd_row_sync: two-flop synchronizer for the active-low keypad row lines.
//   clk, rst_n   : system clock, async active-low reset
//   row_async_i  : raw row lines from the pins
//   row_sync_o   : synchronized row lines (reset to all released)
module kypd_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_async_i,
  output logic [3:0] row_sync_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= row_async_i;
      sync_q <= meta_q;
    end
  end

  assign row_sync_o = sync_q;

endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 active-low matrix keypad, debounces the
// first pressed key and hands its hex code downstream over valid/ready.
//   clk, rst_n : system clock, async active-low reset
//   col_n      : column strobes, exactly one bit low
//   row_n      : row sense lines, active-low, asynchronous
//   kbus       : key_code/key_valid/key_ready/key_held/overrun handshake
//
// state      | meaning
// IDLE       | no key seen
// PRESS_DB   | candidate key seen, counting matching scans
// PRESSED    | key confirmed and held, other keys ignored
// RELEASE_DB | no key seen since PRESSED, counting empty scans
module keypad_scan_encoder
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [3:0]                   col_n,
  input  logic [3:0]                   row_n,
  keypad_scan_encoder_if.master        kbus
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam int             CW       = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0]  DIV_LOAD = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  DB_LIM   = CW'(DEBOUNCE_SCANS);
  localparam bit             DB_ONE   = (DEBOUNCE_SCANS == 1);

  logic [3:0] row_s;

  kypd_row_sync u_row_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_async_i (row_n),
    .row_sync_o  (row_s)
  );

  // Column dwell timer: down-counter, terminal count on zero.
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic          tc;

  assign tc = (div_q == '0);

  always_comb begin
    div_d = tc ? DIV_LOAD : div_q - DW'(1);
    col_d = tc ? col_q + 2'd1 : col_q;
  end

  assign col_n = ~(4'b0001 << col_q);

  // Scan accumulator: keeps the first hit of the scan. Columns are visited in
  // ascending order, so "first hit" already gives lowest-column priority.
  scan_res_t acc_q, acc_d, samp_res;
  logic      scan_done;

  always_comb begin
    samp_res = acc_q;
    if (acc_q.none) begin
      for (int r = 3; r >= 0; r--) begin
        if (!row_s[r]) samp_res = '{none: 1'b0, pos: {2'(r), col_q}};
      end
    end
    scan_done = tc && (col_q == 2'd3);
    acc_d     = acc_q;
    if (tc) acc_d = scan_done ? RES_NONE : samp_res;
  end

  // Debounce FSM, stepped once per completed scan.
  kypd_state_e   state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          confirm;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    confirm = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (!samp_res.none) begin
            cand_d = samp_res.pos;
            cnt_d  = CW'(1);
            if (DB_ONE) begin
              state_d = PRESSED;
              confirm = 1'b1;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (samp_res.none) begin
            state_d = IDLE;
          end else if (samp_res.pos == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LIM) begin
              state_d = PRESSED;
              confirm = 1'b1;
            end
          end else begin
            cand_d = samp_res.pos;
            cnt_d  = CW'(1);
          end
        end
        PRESSED: begin
          if (samp_res.none) begin
            cnt_d   = CW'(1);
            state_d = DB_ONE ? IDLE : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (samp_res.none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LIM) state_d = IDLE;
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register: a confirm only lands if the slot is free or being
  // drained this very cycle; otherwise it is reported and dropped.
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && kbus.key_ready) valid_d = 1'b0;
    if (confirm) begin
      if (!valid_q || kbus.key_ready) begin
        code_d  = legend(cand_d);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= DIV_LOAD;
      col_q   <= 2'd0;
      acc_q   <= RES_NONE;
      state_q <= IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign kbus.key_code  = code_q;
  assign kbus.key_valid = valid_q;
  assign kbus.overrun   = ovr_q;
  assign kbus.key_held  = (state_q == PRESSED) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
module tb_keypad_scan_encoder;

  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] pressed = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q [$];

  keypad_scan_encoder_if kif ();

  keypad_scan_encoder #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .col_n (col_n),
    .row_n (row_n),
    .kbus  (kif.master)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key shorts its row to its column strobe.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Returns at the negedge right after the scan wraps back to column 0.
  task automatic wait_scan_start(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = col_n;
    for (int i = 0; i < 3*SCAN; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col_n == 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = col_n;
    end
  endtask

  task automatic wait_valid(input int max, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (kif.key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!kif.key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (col_n !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0 ||
        kif.overrun !== 1'b0 || kif.key_code !== 4'h0) begin
      n_err++;
      $display("FAIL reset_values: col_n=%b valid=%b held=%b ovr=%b code=%h, want 1110 0 0 0 0",
               col_n, kif.key_valid, kif.key_held, kif.overrun, kif.key_code);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2*SCAN; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_cmp++;
      if (col_n !== exp_col || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0 || kif.overrun !== 1'b0) begin
        n_err++;
        $display("FAIL idle_scan k=%0d: col_n=%b valid=%b held=%b ovr=%b, want col_n=%b 0 0 0",
                 k, col_n, kif.key_valid, kif.key_held, kif.overrun, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_press_6();
    bit ok;
    int n;
    wait_scan_start(ok);
    pressed[1*4+2] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(3*SCAN, n, ok);
    n_cmp++;
    if (!ok || n < 2*SCAN - 4 || n > 2*SCAN + 4) begin
      n_err++;
      $display("FAIL press6_latency: valid seen=%0d after %0d cycles, want about %0d", ok, n, 2*SCAN);
    end
    n_cmp++;
    if (kif.key_code !== exp_q[0] || kif.key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press6_code: code=%h held=%b, want %h 1", kif.key_code, kif.key_held, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    n_cmp++;
    if (kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL press6_consume: valid=%b, want 0", kif.key_valid);
    end
    repeat (SCAN) @(negedge clk);
    n_cmp++;
    if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b1) begin
      n_err++;
      $display("FAIL press6_hold: valid=%b held=%b, want 0 1", kif.key_valid, kif.key_held);
    end
    pressed = '0;
    wait_held_low(4*SCAN, ok);
    n_cmp++;
    if (!ok || kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL press6_release: held dropped=%0d valid=%b, want 1 0", ok, kif.key_valid);
    end
  endtask

  task automatic test_bounce();
    bit ok;
    bit saw_valid;
    bit saw_held;
    wait_scan_start(ok);
    pressed[3*4+0] = 1'b1;
    repeat (SCAN) @(negedge clk);
    pressed = '0;
    saw_valid = 1'b0;
    saw_held = 1'b0;
    for (int i = 0; i < 4*SCAN; i++) begin
      @(negedge clk);
      if (kif.key_valid) saw_valid = 1'b1;
      if (kif.key_held) saw_held = 1'b1;
    end
    n_cmp++;
    if (saw_valid || saw_held) begin
      n_err++;
      $display("FAIL bounce: saw valid=%0d held=%0d, want 0 0", saw_valid, saw_held);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int n;
    int pulse_len;
    wait_scan_start(ok);
    pressed[0*4+3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_valid(3*SCAN, n, ok);
    n_cmp++;
    if (!ok || kif.key_code !== exp_q[0]) begin
      n_err++;
      $display("FAIL ovr_first: valid=%0d code=%h, want 1 %h", ok, kif.key_code, exp_q[0]);
    end
    pressed = '0;
    wait_held_low(4*SCAN, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL ovr_release: held still %b, want 0", kif.key_held);
    end
    wait_scan_start(ok);
    pressed[3*4+0] = 1'b1;
    pulse_len = 0;
    for (int i = 0; i < 4*SCAN; i++) begin
      @(negedge clk);
      if (kif.overrun) pulse_len++;
    end
    n_cmp++;
    if (pulse_len != 1) begin
      n_err++;
      $display("FAIL ovr_pulse: overrun high %0d cycles, want 1", pulse_len);
    end
    n_cmp++;
    if (kif.key_valid !== 1'b1 || kif.key_code !== exp_q[0] || kif.key_held !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_kept: valid=%b code=%h held=%b, want 1 %h 1", kif.key_valid, kif.key_code, kif.key_held, exp_q[0]);
    end
    void'(exp_q.pop_front());
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    pressed = '0;
    wait_held_low(4*SCAN, ok);
    n_cmp++;
    if (!ok || kif.key_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_drain: held dropped=%0d valid=%b, want 1 0", ok, kif.key_valid);
    end
  endtask

  task automatic test_two_keys();
    bit ok;
    int n;
    wait_scan_start(ok);
    pressed[0*4+0] = 1'b1;
    pressed[3*4+3] = 1'b1;
    exp_q.push_back(4'h1);
    wait_valid(3*SCAN, n, ok);
    n_cmp++;
    if (!ok || kif.key_code !== exp_q[0]) begin
      n_err++;
      $display("FAIL two_keys: valid=%0d code=%h, want 1 %h", ok, kif.key_code, exp_q[0]);
    end
    void'(exp_q.pop_front());
    kif.key_ready = 1'b1;
    @(negedge clk);
    kif.key_ready = 1'b0;
    pressed = '0;
    wait_held_low(4*SCAN, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    bit saw;
    wait_scan_start(ok);
    pressed[1*4+1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_valid(3*SCAN, n, ok);
    n_cmp++;
    if (!ok || kif.key_code !== exp_q[0]) begin
      n_err++;
      $display("FAIL rst_mid_pre: valid=%0d code=%h, want 1 %h", ok, kif.key_code, exp_q[0]);
    end
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (col_n !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_held !== 1'b0 ||
        kif.overrun !== 1'b0 || kif.key_code !== 4'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: col_n=%b valid=%b held=%b ovr=%b code=%h, want 1110 0 0 0 0",
               col_n, kif.key_valid, kif.key_held, kif.overrun, kif.key_code);
    end
    pressed = '0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 3*SCAN; i++) begin
      @(negedge clk);
      if (kif.key_valid || kif.overrun || kif.key_held) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_err++;
      $display("FAIL rst_mid_after: output activity seen after reset, want none");
    end
  endtask

  initial begin
    kif.key_ready = 1'b0;
    test_reset();
    test_press_6();
    test_bounce();
    test_overrun();
    test_two_keys();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
